uart_apb_stream_master: RTL and testbench

//  APB master that sits directly upstream of the CoreUARTapb instance and drives its APB slave port.

---
 rtl/uart_apb_stream_master_pkg.sv | 22 ++
 rtl/uart_apb_stream_master_if.sv | 13 +
 rtl/uart_apb_stream_master_xfer.sv | 49 ++++
 rtl/uart_apb_stream_master.sv | 101 ++++++++++
 tb/tb_uart_apb_stream_master.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_apb_stream_master_pkg.sv
// uart_apb_pkg: UART register offsets, CTRL2 bit layout, FSM state encodings and CTRL2 packing helper
package uart_apb_pkg;
  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1 = 5'h08;
  localparam logic [4:0] ADDR_CTRL2 = 5'h0C;
  localparam int CTRL2_BIT8 = 0;
  localparam int CTRL2_PAR_EN = 1;
  localparam int CTRL2_PAR_ODD = 2;
  localparam int CTRL2_BAUD_LSB = 3;
  typedef enum logic [1:0] {ST_CFG, ST_XFER, ST_GUARD, ST_IDLE} state_t;
  typedef enum logic [1:0] {XS_IDLE, XS_SETUP, XS_ACCESS} xfer_state_t;
  function automatic logic [7:0] ctrl2(input logic [12:0] baud, input logic bit8, input logic par_en, input logic par_odd);
    logic [7:0] v;
    v = '0;
    v[CTRL2_BIT8] = bit8;
    v[CTRL2_PAR_EN] = par_en;
    v[CTRL2_PAR_ODD] = par_odd;
    v[7:CTRL2_BAUD_LSB] = baud[12:8];
    return v;
  endfunction
endpackage

// File: rtl/uart_apb_stream_master_if.sv
// uart_apb_if: APB bus to the UART; master drives PADDR/PSEL/PENABLE/PWRITE/PWDATA, slave returns PRDATA/PREADY/PSLVERR
interface uart_apb_if;
  logic [4:0] PADDR;
  logic PSEL;
  logic PENABLE;
  logic PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic PREADY;
  logic PSLVERR;
  modport master(output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave(input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/uart_apb_stream_master_xfer.sv
// apb_master_xfer: single APB SETUP/ACCESS transfer engine; req/addr/wdata/write in, done/rdata/slverr out, APB master port
module apb_master_xfer import uart_apb_pkg::*; (
  input logic PCLK,
  input logic PRESET,
  uart_apb_if.master apb,
  input logic req,
  input logic [4:0] addr,
  input logic [7:0] wdata,
  input logic write,
  output logic done,
  output logic [7:0] rdata,
  output logic slverr
);
  xfer_state_t xs_q, xs_d;
  logic [4:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic pwrite_q, pwrite_d;
  logic take;
  always_comb begin
    take = req && xs_q == XS_IDLE;
    xs_d = xs_q == XS_SETUP ? XS_ACCESS :
           xs_q == XS_ACCESS ? (apb.PREADY ? XS_IDLE : XS_ACCESS) :
           take ? XS_SETUP : XS_IDLE;
    paddr_d = take ? addr : paddr_q;
    pwrite_d = take ? write : pwrite_q;
    pwdata_d = take && write ? wdata : pwdata_q;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      xs_q <= XS_IDLE;
      paddr_q <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      xs_q <= xs_d;
      paddr_q <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end
  assign apb.PSEL = xs_q != XS_IDLE;
  assign apb.PENABLE = xs_q == XS_ACCESS;
  assign apb.PADDR = paddr_q;
  assign apb.PWRITE = pwrite_q;
  assign apb.PWDATA = pwdata_q;
  assign done = xs_q == XS_ACCESS && apb.PREADY;
  assign rdata = apb.PRDATA;
  assign slverr = apb.PSLVERR;
endmodule

// File: rtl/uart_apb_stream_master.sv
// uart_apb_stream_master: configures the UART then bridges s_tx stream to TXDATA writes and RXDATA reads to m_rx stream over APB
module uart_apb_stream_master import uart_apb_pkg::*; #(
  parameter logic [12:0] BAUD_VAL = 13'd1,
  parameter logic BIT8 = 1'b1,
  parameter logic PARITY_EN = 1'b0,
  parameter logic PARITY_ODD = 1'b0,
  parameter int GUARD_CYCLES = 2
) (
  input logic PCLK,
  input logic PRESET,
  input logic [7:0] s_tx_data,
  input logic s_tx_valid,
  output logic s_tx_ready,
  output logic [7:0] m_rx_data,
  output logic [2:0] m_rx_err,
  output logic m_rx_valid,
  input logic m_rx_ready,
  output logic cfg_done,
  output logic apb_err,
  uart_apb_if.master apb,
  input logic TXRDY,
  input logic RXRDY,
  input logic PARITY_ERR,
  input logic OVERFLOW,
  input logic FRAMING_ERR
);
  state_t st_q, st_d;
  logic [1:0] cfg_cnt_q, cfg_cnt_d;
  logic [3:0] guard_q, guard_d;
  logic rd_q, rd_d;
  logic cfg_done_q, cfg_done_d;
  logic apb_err_q, apb_err_d;
  logic m_rx_valid_q, m_rx_valid_d;
  logic [7:0] m_rx_data_q, m_rx_data_d;
  logic [2:0] m_rx_err_q, m_rx_err_d;
  logic req, write, done, slverr, rx_go, tx_go, rx_cap;
  logic [4:0] addr;
  logic [7:0] wdata, rdata;
  always_comb begin
    rx_go = st_q == ST_IDLE && RXRDY && !m_rx_valid_q;
    s_tx_ready = st_q == ST_IDLE && cfg_done_q && TXRDY && !(RXRDY && !m_rx_valid_q);
    tx_go = s_tx_ready && s_tx_valid;
    req = st_q == ST_CFG || rx_go || tx_go;
    write = !rx_go;
    addr = st_q == ST_CFG ? (cfg_cnt_q == 2'd0 ? ADDR_CTRL1 : ADDR_CTRL2) : rx_go ? ADDR_RXDATA : ADDR_TXDATA;
    wdata = st_q == ST_CFG ? (cfg_cnt_q == 2'd0 ? BAUD_VAL[7:0] : ctrl2(BAUD_VAL, BIT8, PARITY_EN, PARITY_ODD)) : s_tx_data;
    rd_d = req ? rx_go : rd_q;
    cfg_cnt_d = cfg_cnt_q + 2'(done && cfg_cnt_q != 2'd2);
    guard_d = done ? 4'(GUARD_CYCLES - 1) : guard_q - 4'(st_q == ST_GUARD && guard_q != 4'd0);
    st_d = req ? ST_XFER :
           st_q == ST_XFER ? (done ? ST_GUARD : ST_XFER) :
           st_q == ST_GUARD && guard_q != 4'd0 ? ST_GUARD :
           st_q == ST_GUARD && cfg_cnt_q != 2'd2 ? ST_CFG : ST_IDLE;
    cfg_done_d = cfg_done_q || st_d == ST_IDLE;
    apb_err_d = apb_err_q || (done && slverr);
    rx_cap = done && rd_q;
    m_rx_valid_d = rx_cap || (m_rx_valid_q && !m_rx_ready);
    m_rx_data_d = rx_cap ? rdata : m_rx_data_q;
    m_rx_err_d = rx_cap ? {FRAMING_ERR, OVERFLOW, PARITY_ERR} : m_rx_err_q;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      st_q <= ST_CFG;
      cfg_cnt_q <= '0;
      guard_q <= '0;
      rd_q <= 1'b0;
      cfg_done_q <= 1'b0;
      apb_err_q <= 1'b0;
      m_rx_valid_q <= 1'b0;
      m_rx_data_q <= '0;
      m_rx_err_q <= '0;
    end else begin
      st_q <= st_d;
      cfg_cnt_q <= cfg_cnt_d;
      guard_q <= guard_d;
      rd_q <= rd_d;
      cfg_done_q <= cfg_done_d;
      apb_err_q <= apb_err_d;
      m_rx_valid_q <= m_rx_valid_d;
      m_rx_data_q <= m_rx_data_d;
      m_rx_err_q <= m_rx_err_d;
    end
  end
  apb_master_xfer u_xfer (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .apb(apb),
    .req(req),
    .addr(addr),
    .wdata(wdata),
    .write(write),
    .done(done),
    .rdata(rdata),
    .slverr(slverr)
  );
  assign cfg_done = cfg_done_q;
  assign apb_err = apb_err_q;
  assign m_rx_valid = m_rx_valid_q;
  assign m_rx_data = m_rx_data_q;
  assign m_rx_err = m_rx_err_q;
endmodule

// File: tb/tb_uart_apb_stream_master.sv
// tb_uart_apb_stream_master: scoreboard bench with behavioural APB UART slave (wait states, RXRDY lag)
module tb_uart_apb_stream_master;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic [7:0] s_tx_data = '0;
  logic s_tx_valid = 1'b0;
  logic s_tx_ready;
  logic [7:0] m_rx_data;
  logic [2:0] m_rx_err;
  logic m_rx_valid;
  logic m_rx_ready = 1'b0;
  logic cfg_done, apb_err;
  logic TXRDY = 1'b1;
  logic RXRDY;
  logic PARITY_ERR = 1'b0, OVERFLOW = 1'b0, FRAMING_ERR = 1'b0;
  logic slverr_en = 1'b0;
  logic [7:0] rx_byte = '0;
  int tests, fails, wait_states, wcnt, rx_push, rx_pop, rd_cnt, acc_run;
  logic [13:0] exp_apb[$];
  logic [10:0] exp_rx[$];
  int acc_len[$];
  uart_apb_if apb();
  uart_apb_stream_master #(.BAUD_VAL(13'h1A5), .BIT8(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .GUARD_CYCLES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
    .m_rx_data(m_rx_data), .m_rx_err(m_rx_err), .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready),
    .cfg_done(cfg_done), .apb_err(apb_err), .apb(apb),
    .TXRDY(TXRDY), .RXRDY(RXRDY), .PARITY_ERR(PARITY_ERR), .OVERFLOW(OVERFLOW), .FRAMING_ERR(FRAMING_ERR)
  );
  always #5 PCLK = ~PCLK;
  assign apb.PREADY = apb.PENABLE && wcnt >= wait_states;
  assign apb.PRDATA = rx_byte;
  assign apb.PSLVERR = slverr_en && apb.PENABLE;
  always @(posedge PCLK) begin
    wcnt <= (apb.PSEL && apb.PENABLE && !apb.PREADY) ? wcnt + 1 : 0;
    if (!PRESET && apb.PSEL && apb.PENABLE && apb.PREADY && !apb.PWRITE) rx_pop <= rx_pop + 1;
    RXRDY <= rx_push != rx_pop;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [13:0] xfer(input logic w, input logic [4:0] a, input logic [7:0] d);
    return {w, a, w ? d : 8'h00};
  endfunction
  function automatic logic [31:0] outs();
    return {1'b0, apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, cfg_done, apb_err, m_rx_valid, s_tx_ready, m_rx_data, m_rx_err};
  endfunction
  initial forever begin
    @(negedge PCLK);
    if (PRESET) acc_run = 0;
    else if (apb.PSEL && apb.PENABLE) begin
      acc_run++;
      if (apb.PREADY) begin
        acc_len.push_back(acc_run);
        acc_run = 0;
        if (!apb.PWRITE) rd_cnt++;
        if (exp_apb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL apb_unexpected: got 0x%0h with nothing expected", xfer(apb.PWRITE, apb.PADDR, apb.PWDATA));
        end else check("apb_xfer", 32'(xfer(apb.PWRITE, apb.PADDR, apb.PWDATA)), 32'(exp_apb.pop_front()));
      end
    end
  end
  initial forever begin
    @(negedge PCLK);
    if (!PRESET && m_rx_valid && m_rx_ready) begin
      if (exp_rx.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got 0x%0h with nothing expected", {m_rx_err, m_rx_data});
      end else check("rx_beat", 32'({m_rx_err, m_rx_data}), 32'(exp_rx.pop_front()));
    end
  end
  task automatic wait_cfg();
    int lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge PCLK);
      if (cfg_done) begin
        lat = k;
        break;
      end
    end
    check("cfg_latency", lat, 10);
    check("cfg_writes", exp_apb.size(), 0);
  endtask
  task automatic send_tx(input logic [7:0] d, output int lat);
    logic hs = 1'b0;
    lat = -1;
    @(posedge PCLK);
    #1 s_tx_data = d;
    s_tx_valid = 1'b1;
    for (int k = 0; k < 100 && !hs; k++) begin
      @(negedge PCLK);
      hs = s_tx_ready;
    end
    check("tx_handshake", hs, 1);
    @(posedge PCLK);
    #1 s_tx_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge PCLK);
      if (s_tx_ready) begin
        lat = k;
        break;
      end
    end
  endtask
  task automatic wait_empty();
    for (int k = 0; k < 100 && (exp_apb.size() != 0 || exp_rx.size() != 0); k++) @(negedge PCLK);
    check("queues_drained", exp_apb.size() + exp_rx.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, rd0;
    logic seen;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_outputs", outs(), 0);
    exp_apb.push_back(xfer(1'b1, 5'h08, 8'hA5));
    exp_apb.push_back(xfer(1'b1, 5'h0C, 8'h0B));
    @(posedge PCLK);
    #1 PRESET = 1'b0;
    wait_cfg();
    check("apb_err_after_cfg", apb_err, 0);
    exp_apb.push_back(xfer(1'b1, 5'h00, 8'h55));
    send_tx(8'h55, lat);
    check("tx_latency", lat, 5);
    repeat (10) @(negedge PCLK);
    check("tx_single_write", exp_apb.size(), 0);
    rd0 = rd_cnt;
    @(posedge PCLK);
    #1 rx_byte = 8'hC3;
    FRAMING_ERR = 1'b1;
    exp_apb.push_back(xfer(1'b0, 5'h04, 8'h00));
    exp_rx.push_back({3'b100, 8'hC3});
    rx_push++;
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge PCLK);
      if (m_rx_valid) begin
        lat = k;
        break;
      end
    end
    check("rx_latency", lat, 5);
    check("rx_data", m_rx_data, 8'hC3);
    check("rx_err", m_rx_err, 3'b100);
    rx_push++;
    repeat (15) @(negedge PCLK);
    check("rx_backpressure_reads", rd_cnt - rd0, 1);
    check("rx_held_valid", m_rx_valid, 1);
    check("rx_held_data", m_rx_data, 8'hC3);
    @(posedge PCLK);
    #1 rx_byte = 8'h3C;
    FRAMING_ERR = 1'b0;
    OVERFLOW = 1'b1;
    exp_apb.push_back(xfer(1'b0, 5'h04, 8'h00));
    exp_rx.push_back({3'b010, 8'h3C});
    m_rx_ready = 1'b1;
    wait_empty();
    repeat (6) @(negedge PCLK);
    @(posedge PCLK);
    #1 OVERFLOW = 1'b0;
    rx_byte = 8'h5A;
    wait_states = 3;
    acc_len.delete();
    exp_apb.push_back(xfer(1'b0, 5'h04, 8'h00));
    exp_rx.push_back({3'b000, 8'h5A});
    exp_apb.push_back(xfer(1'b1, 5'h00, 8'hA7));
    rx_push++;
    send_tx(8'hA7, lat);
    check("tx_after_rx_latency", lat, 8);
    check("access_count", acc_len.size(), 2);
    foreach (acc_len[i]) check("access_hold", acc_len[i], 4);
    wait_empty();
    wait_states = 0;
    check("apb_err_clear", apb_err, 0);
    slverr_en = 1'b1;
    exp_apb.push_back(xfer(1'b1, 5'h00, 8'h81));
    send_tx(8'h81, lat);
    slverr_en = 1'b0;
    check("apb_err_set", apb_err, 1);
    exp_apb.push_back(xfer(1'b1, 5'h00, 8'h42));
    send_tx(8'h42, lat);
    check("tx_after_err", lat, 5);
    check("apb_err_sticky", apb_err, 1);
    wait_states = 10;
    @(posedge PCLK);
    #1 s_tx_data = 8'h99;
    s_tx_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge PCLK);
      seen = s_tx_ready;
    end
    @(posedge PCLK);
    #1 s_tx_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge PCLK);
      seen = apb.PENABLE;
    end
    check("abort_in_access", seen, 1);
    @(posedge PCLK);
    #1 PRESET = 1'b1;
    @(negedge PCLK);
    check("reset_is_sync", apb.PSEL, 1);
    @(negedge PCLK);
    check("psel_abort", apb.PSEL, 0);
    check("reset_outputs_again", outs(), 0);
    wait_states = 0;
    exp_apb.push_back(xfer(1'b1, 5'h08, 8'hA5));
    exp_apb.push_back(xfer(1'b1, 5'h0C, 8'h0B));
    @(posedge PCLK);
    #1 PRESET = 1'b0;
    wait_cfg();
    wait_empty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
